rdmx_packet_checker: RTL and testbench

- Receive-side counterpart of the RDMX packet generator: a 512-bit AXI-Stream sink that consumes RDMX test packets (from the CMAC RX path or a loopback) and verifies them beat by beat.
- Checks RDMX header, 32-bit sequence counter, payload fill, packet length and tuser on every packet.
- Keeps packet/error statistics and captures the first failure for the control/status register block.

---
 rtl/rdmx_packet_checker_if.sv | 12 +
 rtl/rdmx_packet_checker.sv | 148 ++++++++++++++
 tb/tb_rdmx_packet_checker.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdmx_packet_checker_if.sv
// 512-bit AXI-Stream link carrying RDMX test packets into the checker.
// The master drives data/valid/user/last and the slave (checker) returns ready.
interface rdmx_packet_checker_if;
    logic [511:0] tdata;
    logic         tvalid;
    logic         tuser;
    logic         tlast;
    logic         tready;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/rdmx_packet_checker.sv
// RDMX receive-side packet checker: verifies header, sequence, payload fill,
// length and tuser on every beat, and keeps statistics plus first-error capture.

module rdmx_encoder (
    input  logic [63:0]  target_address,
    input  logic [31:0]  payload_length,
    output logic [479:0] header
);
    localparam logic [31:0] MAGIC  = 32'h5244_4D58;
    localparam logic [7:0]  OPCODE = 8'h01;

    assign header = {344'h0, OPCODE, MAGIC, payload_length, target_address};
endmodule

module rdmx_packet_checker #(
    parameter int PAYLOAD_SIZE = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] max_packets,
    output logic        idle,
    output logic        done,
    output logic        pass,
    output logic [63:0] packets_rcvd,
    output logic [31:0] error_count,
    output logic [5:0]  err_flags,
    output logic [2:0]  first_err_code,
    output logic [63:0] first_err_packet,
    output logic [7:0]  first_err_cycle,
    output logic [31:0] stray_beats,
    rdmx_packet_checker_if.slave axis
);
    localparam int          LAST_CYCLE = PAYLOAD_SIZE / 64 + 1;
    localparam logic [7:0]  LAST_BEAT  = 8'(LAST_CYCLE);
    localparam logic [31:0] ADDR_STEP  = 32'(PAYLOAD_SIZE);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state, state_next;
    logic [63:0]   max_lat;
    logic [7:0]    beat;
    logic [31:0]   exp_seq;
    logic [31:0]   exp_addr;
    logic [479:0]  exp_hdr;
    logic [31:0]   beat_seq;
    logic          xfer, run_xfer, final_pkt;
    logic          pay_ok;
    logic [5:0]    errs;
    logic [2:0]    err_cnt;
    logic [2:0]    err_code;
    logic [32:0]   err_sum;

    rdmx_encoder u_encoder (
        .target_address ({32'h0, exp_addr}),
        .payload_length (ADDR_STEP),
        .header         (exp_hdr)
    );

    assign beat_seq  = axis.tdata[511:480];
    assign xfer      = axis.tvalid & axis.tready;
    assign run_xfer  = xfer & (state == S_RUN) & ~start;
    assign final_pkt = run_xfer & axis.tlast & (packets_rcvd + 64'd1 == max_lat);

    always_comb begin
        pay_ok = 1'b1;
        for (int unsigned w = 0; w < 15; w++) begin
            if (axis.tdata[w*32 +: 32] != beat_seq) pay_ok = 1'b0;
        end
    end

    // Beat counter never reads 0, so "not beat 1" is the same as "beat >= 2".
    always_comb begin
        errs[0] = (beat == 8'd1) && (axis.tdata[479:0] != exp_hdr);
        errs[1] = (beat_seq != exp_seq);
        errs[2] = (beat != 8'd1) && !pay_ok;
        errs[3] = axis.tlast && (beat < LAST_BEAT);
        errs[4] = !axis.tlast && (beat == LAST_BEAT);
        errs[5] = axis.tlast && axis.tuser;
    end

    always_comb begin
        err_cnt  = '0;
        err_code = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            err_cnt = err_cnt + 3'(errs[i]);
            if (errs[i] && err_code == '0) err_code = 3'(i + 1);
        end
    end

    assign err_sum = {1'b0, error_count} + {30'b0, err_cnt};

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start)          state_next = (max_packets == '0) ? S_IDLE : S_RUN;
        else if (final_pkt) state_next = S_IDLE;
    end

    always_comb begin
        idle        = (state == S_IDLE) && !start;
        pass        = done && (error_count == '0);
        axis.tready = 1'b1;
    end

    // Start re-initialises exactly like reset; a beat in the start cycle is dropped.
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            max_lat          <= max_packets;
            done             <= resetn && (max_packets == '0);
            packets_rcvd     <= '0;
            error_count      <= '0;
            err_flags        <= '0;
            first_err_code   <= '0;
            first_err_packet <= '0;
            first_err_cycle  <= '0;
            stray_beats      <= '0;
            beat             <= 8'd1;
            exp_seq          <= '0;
            exp_addr         <= '0;
        end else begin
            if (xfer && state == S_IDLE && stray_beats != '1)
                stray_beats <= stray_beats + 32'd1;
            if (run_xfer) begin
                exp_seq     <= beat_seq + 32'd1;
                err_flags   <= err_flags | errs;
                error_count <= err_sum[32] ? '1 : err_sum[31:0];
                if (first_err_code == '0 && errs != '0) begin
                    first_err_code   <= err_code;
                    first_err_packet <= packets_rcvd;
                    first_err_cycle  <= beat;
                end
                if (axis.tlast) begin
                    beat         <= 8'd1;
                    packets_rcvd <= packets_rcvd + 64'd1;
                    exp_addr     <= exp_addr + ADDR_STEP;
                    if (final_pkt) done <= 1'b1;
                end else if (beat != '1) begin
                    beat <= beat + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rdmx_packet_checker.sv
// Randomized scoreboard bench for rdmx_packet_checker: a behavioural model predicts
// the statistics after every clocked event and a monitor compares them one cycle later.
module tb_rdmx_packet_checker;
    localparam int PS = 4096;
    localparam int LC = PS / 64 + 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [63:0] max_packets;
    logic        idle, done, pass;
    logic [63:0] packets_rcvd;
    logic [31:0] error_count;
    logic [5:0]  err_flags;
    logic [2:0]  first_err_code;
    logic [63:0] first_err_packet;
    logic [7:0]  first_err_cycle;
    logic [31:0] stray_beats;

    rdmx_packet_checker_if bus ();

    rdmx_packet_checker #(.PAYLOAD_SIZE(PS)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start),
        .max_packets      (max_packets),
        .idle             (idle),
        .done             (done),
        .pass             (pass),
        .packets_rcvd     (packets_rcvd),
        .error_count      (error_count),
        .err_flags        (err_flags),
        .first_err_code   (first_err_code),
        .first_err_packet (first_err_packet),
        .first_err_cycle  (first_err_cycle),
        .stray_beats      (stray_beats),
        .axis             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rcvd;
        logic [31:0] errc;
        logic [5:0]  flags;
        logic [2:0]  code;
        logic [63:0] fpkt;
        logic [7:0]  fcyc;
        logic [31:0] stray;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    bit          m_run, m_done;
    logic [63:0] m_max, m_rcvd, m_fpkt;
    logic [31:0] m_errc, m_stray, m_seq, m_addr;
    logic [5:0]  m_flags;
    logic [2:0]  m_code;
    logic [7:0]  m_fcyc;
    int          m_beat;

    // Generator state
    logic [31:0] g_seq, g_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [479:0] hdr(input logic [31:0] a);
        return {344'h0, 8'h01, 32'h5244_4D58, 32'(PS), 32'h0, a};
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.rcvd = m_rcvd; e.errc = m_errc; e.flags = m_flags; e.code = m_code;
        e.fpkt = m_fpkt; e.fcyc = m_fcyc; e.stray = m_stray; e.done = m_done;
        return e;
    endfunction

    task automatic model_step(input bit rst_n, input bit st, input logic [63:0] mp,
                              input bit v, input logic [511:0] d, input bit l, input bit u);
        bit e [6];
        logic [31:0] s;
        if (!rst_n || st) begin
            m_rcvd = 0; m_errc = 0; m_flags = 0; m_code = 0; m_fpkt = 0; m_fcyc = 0;
            m_stray = 0; m_seq = 0; m_addr = 0; m_beat = 1;
            m_max = mp; m_done = rst_n && (mp == 0); m_run = rst_n && (mp != 0);
            return;
        end
        if (!v) return;
        if (!m_run) begin
            if (m_stray != 32'hFFFF_FFFF) m_stray++;
            return;
        end
        s = d[511:480];
        e[0] = (m_beat == 1) && (d[479:0] != hdr(m_addr));
        e[1] = (s != m_seq);
        e[2] = (m_beat >= 2) && (d[479:0] != {15{s}});
        e[3] = l && (m_beat < LC);
        e[4] = !l && (m_beat == LC);
        e[5] = l && u;
        for (int i = 0; i < 6; i++) begin
            if (e[i]) begin
                m_flags[i] = 1'b1;
                if (m_errc != 32'hFFFF_FFFF) m_errc++;
                if (m_code == 0) begin
                    m_code = 3'(i + 1);
                    m_fpkt = m_rcvd;
                    m_fcyc = 8'(m_beat);
                end
            end
        end
        m_seq = s + 32'd1;
        if (l) begin
            m_beat = 1;
            m_rcvd++;
            m_addr = m_addr + 32'(PS);
            if (m_rcvd == m_max) begin
                m_run = 0;
                m_done = 1;
            end
        end else if (m_beat < 255) begin
            m_beat++;
        end
    endtask

    task automatic drive(input bit st, input logic [63:0] mp, input bit v,
                         input logic [511:0] d, input bit l, input bit u, input bit rst_n);
        start = st; max_packets = mp; resetn = rst_n;
        bus.tvalid = v; bus.tdata = d; bus.tlast = l; bus.tuser = u;
        model_step(rst_n, st, mp, v, d, l, u);
        if (!rst_n || st || v) sb.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        logic [511:0] junk;
        for (int i = 0; i < 16; i++) junk[i*32 +: 32] = $urandom;
        drive(0, '0, 0, junk, 0, 0, 1);
    endtask

    task automatic do_start(input logic [63:0] mp);
        drive(1, mp, 0, '0, 0, 0, 1);
        g_seq = 0;
        g_addr = 0;
    endtask

    function automatic logic [511:0] make_beat(input int b);
        return (b == 1) ? {g_seq, hdr(g_addr)} : {g_seq, {15{g_seq}}};
    endfunction

    task automatic send_packet(input int len, input int skip_beat, input int flip_beat,
                               input int flip_bit, input bit user_last, input bit gaps);
        for (int b = 1; b <= len; b++) begin
            logic [511:0] d;
            if (b == skip_beat) g_seq++;
            d = make_beat(b);
            if (b == flip_beat) d[flip_bit] = ~d[flip_bit];
            drive(0, '0, 1, d, b == len, user_last && (b == len), 1);
            g_seq++;
            if (gaps && $urandom_range(7, 0) == 0) idle_cycle();
        end
        g_addr = g_addr + 32'(PS);
    endtask

    task automatic chk_stats(input string tag, input logic [63:0] rcvd, input logic [31:0] errc,
                             input logic [5:0] flags, input logic [2:0] code,
                             input logic [63:0] fpkt, input logic [7:0] fcyc,
                             input bit dn, input bit ps);
        check({tag, ".packets_rcvd"}, packets_rcvd, rcvd);
        check({tag, ".error_count"}, error_count, 64'(errc));
        check({tag, ".err_flags"}, err_flags, 64'(flags));
        check({tag, ".first_err_code"}, first_err_code, 64'(code));
        check({tag, ".first_err_packet"}, first_err_packet, fpkt);
        check({tag, ".first_err_cycle"}, first_err_cycle, 64'(fcyc));
        check({tag, ".done"}, done, 64'(dn));
        check({tag, ".pass"}, pass, 64'(ps));
    endtask

    // Monitor: every clocked event (reset, start or valid beat) has one queued prediction.
    always @(posedge clk) begin
        if (!resetn || start || bus.tvalid) begin
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb.packets_rcvd", packets_rcvd, e.rcvd);
                check("sb.error_count", error_count, 64'(e.errc));
                check("sb.err_flags", err_flags, 64'(e.flags));
                check("sb.first_err_code", first_err_code, 64'(e.code));
                check("sb.first_err_packet", first_err_packet, e.fpkt);
                check("sb.first_err_cycle", first_err_cycle, 64'(e.fcyc));
                check("sb.stray_beats", stray_beats, 64'(e.stray));
                check("sb.done", done, 64'(e.done));
                check("sb.pass", pass, 64'(e.done && e.errc == 0));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete, %0d events pending", sb.size());
        $fatal(1);
    end

    initial begin
        bus.tvalid = 0; bus.tdata = '0; bus.tlast = 0; bus.tuser = 0;
        drive(0, '0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, '0, 0, 0, 0);
        chk_stats("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.stray_beats", stray_beats, 0);
        check("reset.idle", idle, 1);
        check("reset.tready", bus.tready, 1);

        // Eight ideal packets
        do_start(8);
        check("run.idle", idle, 0);
        for (int p = 0; p < 8; p++) send_packet(LC, -1, -1, 0, 0, 1);
        chk_stats("ideal", 8, 0, 0, 0, 0, 0, 1, 1);
        check("ideal.idle", idle, 1);

        // Sequence jump on beat 10 of packet 2
        do_start(8);
        for (int p = 0; p < 8; p++) send_packet(LC, (p == 2) ? 10 : -1, -1, 0, 0, 0);
        chk_stats("seqskip", 8, 1, 6'b000010, 2, 2, 10, 1, 0);

        // Short packet then a normal one at address 0x1000
        do_start(2);
        send_packet(40, -1, -1, 0, 0, 0);
        send_packet(LC, -1, -1, 0, 0, 0);
        chk_stats("short", 2, 1, 6'b001000, 4, 0, 40, 1, 0);

        // Long packet closing on beat 66
        do_start(2);
        send_packet(LC + 1, -1, -1, 0, 0, 0);
        send_packet(LC, -1, -1, 0, 0, 0);
        chk_stats("long", 2, 1, 6'b010000, 5, 0, 65, 1, 0);

        // Start colliding with a valid beat mid-run, then stray beats while idle
        do_start(4);
        send_packet(10, -1, -1, 0, 0, 0);
        for (int b = 1; b <= 5; b++) begin
            drive(0, '0, 1, make_beat(b), 0, 0, 1);
            g_seq++;
        end
        drive(1, 0, 1, make_beat(6), 0, 0, 1);
        chk_stats("collide", 0, 0, 0, 0, 0, 0, 1, 1);
        check("collide.stray_beats", stray_beats, 0);
        for (int b = 0; b < 5; b++) drive(0, '0, 1, {16{$urandom}}, b == 4, 0, 1);
        check("stray.stray_beats", stray_beats, 5);
        check("stray.packets_rcvd", packets_rcvd, 0);
        check("stray.idle", idle, 1);

        // Payload word 3 corrupted on beat 20 plus tuser on tlast
        do_start(1);
        send_packet(LC, -1, 20, 96 + 5, 1, 0);
        chk_stats("pay_tuser", 1, 2, 6'b100100, 3, 0, 20, 1, 0);

        // Randomized packets with injected faults
        do_start(6);
        for (int p = 0; p < 6; p++) begin
            int r, len, flip, skip;
            r = $urandom_range(9, 0);
            len = (r == 6) ? LC - 1 - $urandom_range(20, 0) :
                  (r == 7) ? LC + 1 + $urandom_range(2, 0) : LC;
            flip = ($urandom_range(2, 0) == 0) ? $urandom_range(len, 1) : -1;
            skip = ($urandom_range(3, 0) == 0) ? $urandom_range(len, 2) : -1;
            send_packet(len, skip, flip, $urandom_range(511, 0), $urandom_range(3, 0) == 0, 1);
        end
        check("random.packets_rcvd", packets_rcvd, 6);
        check("random.done", done, 1);

        // Reset in the middle of a packet
        do_start(3);
        for (int b = 1; b <= 30; b++) begin
            drive(0, '0, 1, make_beat(b), 0, 0, 1);
            g_seq++;
        end
        drive(0, '0, 1, make_beat(31), 0, 0, 0);
        drive(0, '0, 0, '0, 0, 0, 0);
        chk_stats("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("midreset.idle", idle, 1);
        do_start(1);
        send_packet(LC, -1, -1, 0, 0, 0);
        chk_stats("after_reset", 1, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("sb_drain", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
